accumulator_scheduler: RTL and testbench
========================================

Name: accumulator_scheduler

Overview:
- Round-robin scheduler that shares one adder_with_feedback accumulator (16-bit, registered, out <= out + in every clk, cleared by its active-high reset) among NUM_REQ requesters.
- Each requester streams a burst of words. The scheduler grants one burst at a time, clears the accumulator, and steers the granted words into it. It returns the burst sum with requester ID, beat count and overflow flag over a valid/ready result port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, data and accumulator width
- CNT_W, 8, beat-counter width
- ID_W, $clog2(NUM_REQ), result ID width (derived)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-low; reset==0 at a rising edge initialises the block
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*WIDTH  packed words, requester i at [i*WIDTH +: WIDTH]
- req_last  in  NUM_REQ  marks final word of a burst (qualified by req_valid)
- req_ready  out  NUM_REQ  per-requester accept
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- acc_in  out  WIDTH  to accumulator in
- acc_reset  out  1  to accumulator reset (active-high)
- acc_out  in  WIDTH  from accumulator out
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_data  out  WIDTH  burst sum, modulo 2^WIDTH
- res_id  out  ID_W  index of requester that owned the burst
- res_count  out  CNT_W  accepted beats, saturating at all-ones
- res_ovf  out  1  sticky: at least one addition in the burst carried out of WIDTH bits

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, RR pointer=0, grant=0, req_ready=0, res_valid=0, res_id=0, res_count=0, res_ovf=0.
  - acc_reset=1 while reset==0 (acc_reset = ~reset | state==IDLE); acc_in=0.
  - Reset mid-burst abandons the burst; no result is produced.
- State IDLE:
  - acc_reset=1, acc_in=0, req_ready=0.
  - If any req_valid: pick the first set bit searching upward from the RR pointer, wrapping. Latch grant and res_id, clear count and ovf, go to RUN.
  - The accumulator is 0 on entry to RUN.
- State RUN:
  - acc_reset=0. req_ready[g]=1 for the owner g only; all other req_ready bits are 0.
  - acc_in = req_data[g] when req_valid[g], else 0, so bubbles add nothing.
  - Beat accepted = req_valid[g] & req_ready[g]. On each accepted beat:
    - count increments, saturating.
    - ovf |= carry of (acc_out + acc_in) at WIDTH+1 bits.
  - Accepted beat with req_last[g] -> RESULT.
  - Requests from other requesters are ignored until IDLE.
- State RESULT:
  - acc_reset=0, acc_in=0, so the accumulator holds.
  - res_valid=1, res_data=acc_out (includes the last beat), req_ready=0.
  - res_id, res_count and res_ovf are stable while res_valid=1.
  - res_valid & res_ready -> IDLE; RR pointer = (g+1) mod NUM_REQ; grant cleared.
- Latency:
  - res_valid rises 1 cycle after the last-beat edge.
  - Minimum gap between bursts is 1 IDLE cycle (the accumulator clear).
  - A one-word burst takes grant cycle, 1 RUN cycle, then RESULT.
- Arithmetic: sum wraps modulo 2^WIDTH; overflow is reported only via res_ovf.
- Boundaries:
  - req_last without req_valid is ignored.
  - Owner deasserting req_valid mid-burst stalls with no time limit.
  - res_ready held low stalls in RESULT indefinitely.
  - Count saturates at 2^CNT_W-1.
  - All requesters valid every cycle -> grants rotate 0,1,2,3,0,...

Test Plan:
- Reset then requester 0 sends 5,5,7(last) -> grant=0001, res_valid one cycle after the beat with last; res_data=17, res_id=0, res_count=3, res_ovf=0. With res_ready=1: IDLE next, then acc_reset=1.
- All four req_valid held, each sends one word 1/2/3/4 with last -> results in order res_id 0,1,2,3, res_data 1,2,3,4; grant never has two bits set.
- Requester 2 sends 16'hFFF0, 16'h0020(last) -> res_data=16'h0010, res_ovf=1, res_count=2.
- Requester 1 sends 10, bubble 3 cycles, 10(last) with res_ready=0 for 4 cycles -> res_data=20 held stable with res_valid=1 until res_ready; no new grant during RESULT.
- Reset driven to 0 mid-burst after 2 beats -> next cycle grant=0, res_valid=0, acc_reset=1, RR pointer=0. A new burst of 3 from requester 3 then yields res_data=3, res_count=1.

Source files
------------

// File: rtl/accumulator_scheduler.sv
// -----------------------------------------------------------------------------
// accumulator_scheduler
//
// Round-robin arbiter that time-shares one external registered accumulator
// (out <= out + in each clock, cleared by its active-high reset) among
// NUM_REQ requesters. One burst is granted at a time: the accumulator is
// cleared while idle, the owner's words are steered into it, and the burst
// sum is returned with owner ID, beat count and carry-out flag.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous, active-low initialisation
//   req_valid  : per-requester word valid
//   req_data   : packed words, requester i at [i*WIDTH +: WIDTH]
//   req_last   : final word of a burst (qualified by req_valid)
//   req_ready  : per-requester accept, only the owner while running
//   grant      : one-hot current owner, zero when idle
//   acc_in     : word fed to the accumulator (zero on bubbles / outside RUN)
//   acc_reset  : accumulator clear, high while idle or in reset
//   acc_out    : accumulator value
//   res_valid  : result available
//   res_ready  : result accepted
//   res_data   : burst sum modulo 2^WIDTH
//   res_id     : requester that owned the burst
//   res_count  : accepted beats, saturating at all-ones
//   res_ovf    : some addition in the burst carried out of WIDTH bits
// -----------------------------------------------------------------------------
module accumulator_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int CNT_W   = 8,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]       req_last,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic [NUM_REQ-1:0]       grant,
   output logic [WIDTH-1:0]         acc_in,
   output logic                     acc_reset,
   input  logic [WIDTH-1:0]         acc_out,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_data,
   output logic [ID_W-1:0]          res_id,
   output logic [CNT_W-1:0]         res_count,
   output logic                     res_ovf
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESULT} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [ID_W-1:0]    r_ptr;
   logic [ID_W-1:0]    r_id;
   logic [NUM_REQ-1:0] r_grant;
   logic [CNT_W-1:0]   r_count;
   logic               r_ovf;

   logic [WIDTH-1:0]   w_data [NUM_REQ];
   logic [ID_W:0]      w_idx;
   logic [ID_W-1:0]    w_pick;
   logic               w_found;
   logic               w_own_valid;
   logic               w_own_last;
   logic               w_beat;
   logic [WIDTH-1:0]   w_acc_in;
   logic [WIDTH-1:0]   w_wrap;
   logic               w_carry;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_data[gi] = req_data[gi*WIDTH +: WIDTH];
   end

   // Round-robin search: first valid requester at or above the pointer,
   // wrapping. The index carries one spare bit so ptr+k never overflows
   // before the modulo fold.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
            w_idx = w_idx - (ID_W+1)'(NUM_REQ);
         end
         if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[ID_W-1:0];
         end
      end
   end

   assign w_own_valid = req_valid[r_id];
   assign w_own_last  = req_last[r_id];
   assign w_beat      = (r_state == S_RUN) && w_own_valid;

   // Bubbles feed zero so the accumulator only sees accepted beats.
   assign w_acc_in = w_beat ? w_data[r_id] : '0;

   // Carry out of WIDTH bits shows up as the wrapped sum dropping below acc_out.
   assign w_wrap  = acc_out + w_acc_in;
   assign w_carry = (w_wrap < acc_out);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_found)                w_next = S_RUN;
         S_RUN:    if (w_beat && w_own_last)   w_next = S_RESULT;
         S_RESULT: if (res_ready)              w_next = S_IDLE;
         default:                              w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ptr   <= '0;
         r_id    <= '0;
         r_grant <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= NUM_REQ'(1) << w_pick;
                  r_id    <= w_pick;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  if (r_count != '1) begin
                     r_count <= r_count + CNT_W'(1);
                  end
                  r_ovf <= r_ovf | w_carry;
               end
            end
            S_RESULT: begin
               if (res_ready) begin
                  r_grant <= '0;
                  r_ptr   <= (r_id == ID_W'(NUM_REQ-1)) ? '0 : r_id + ID_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign grant     = r_grant;
   assign req_ready = (r_state == S_RUN) ? r_grant : '0;
   assign acc_in    = w_acc_in;
   // Clear the accumulator while idle and throughout reset, so a new owner
   // always starts from zero.
   assign acc_reset = ~reset | (r_state == S_IDLE);
   assign res_valid = (r_state == S_RESULT);
   assign res_data  = acc_out;
   assign res_id    = r_id;
   assign res_count = r_count;
   assign res_ovf   = r_ovf;

endmodule

// File: tb/tb_accumulator_scheduler.sv
// -----------------------------------------------------------------------------
// tb_accumulator_scheduler
//
// Drives bursts on four requesters against a behavioural accumulator, keeps
// per-requester queues of expected burst results (sum, beat count, carry flag)
// computed with plain integer arithmetic, and checks every returned result
// plus the round-robin owner order and the handshake timing rules.
// -----------------------------------------------------------------------------
module tb_accumulator_scheduler;

   localparam int N = 4;
   localparam int W = 16;
   localparam int C = 8;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      logic         bub;
   } word_t;

   typedef struct {
      logic [W-1:0] sum;
      int           cnt;
      logic         ovf;
   } exp_t;

   logic           clk;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   grant;
   logic [W-1:0]   acc_in;
   logic           acc_reset;
   logic [W-1:0]   acc_out;
   logic           res_valid;
   logic           res_ready;
   logic [W-1:0]   res_data;
   logic [1:0]     res_id;
   logic [C-1:0]   res_count;
   logic           res_ovf;

   logic           v [N];
   logic [W-1:0]   d [N];
   logic           l [N];
   logic           took [N];
   logic           shown_bub [N];
   int             beats [N];

   word_t          wq [N][$];
   exp_t           exp_q [N][$];
   logic [W-1:0]   bw [$];
   int             exp_ptr;

   int             n_cmp;
   int             n_err;

   accumulator_scheduler #(.NUM_REQ(N), .WIDTH(W), .CNT_W(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .acc_in    (acc_in),
      .acc_reset (acc_reset),
      .acc_out   (acc_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_count (res_count),
      .res_ovf   (res_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared accumulator: registered, cleared by its active-high reset.
   always @(posedge clk) begin
      if (acc_reset) acc_out <= '0;
      else           acc_out <= acc_out + acc_in;
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_pack
      assign req_valid[gi]          = v[gi];
      assign req_data[gi*W +: W]    = d[gi];
      assign req_last[gi]           = l[gi];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int outstanding();
      int t;
      t = 0;
      for (int r = 0; r < N; r++) t += exp_q[r].size();
      return t;
   endfunction

   // Queue the words in bw for requester r and push the expected result.
   task automatic issue(input int r, input int fixed_bub, input bit rnd_bub);
      word_t w;
      exp_t  e;
      int    s;
      int    n;
      int    nb;
      s     = 0;
      e.ovf = 1'b0;
      n     = bw.size();
      for (int i = 0; i < n; i++) begin
         s = s + int'(bw[i]);
         if (s > 65535) begin
            e.ovf = 1'b1;
            s     = s - 65536;
         end
         w.data = bw[i];
         w.last = (i == n-1);
         w.bub  = 1'b0;
         wq[r].push_back(w);
         if (i != n-1) begin
            nb = (i == 0) ? fixed_bub : 0;
            if (rnd_bub && $urandom_range(0, 3) == 0) nb = nb + int'($urandom_range(1, 3));
            for (int b = 0; b < nb; b++) begin
               w.bub  = 1'b1;
               w.last = 1'b1;
               w.data = 16'($urandom);
               wq[r].push_back(w);
            end
         end
      end
      e.sum = 16'(s);
      e.cnt = (n > 255) ? 255 : n;
      exp_q[r].push_back(e);
   endtask

   task automatic drain(input int max, input bit rnd);
      bit done;
      done = 1'b0;
      for (int i = 0; i < max && !done; i++) begin
         @(posedge clk); #1;
         if (rnd) res_ready = 1'($urandom_range(0, 1));
         done = (outstanding() == 0);
      end
      res_ready = 1'b1;
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", outstanding());
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input bit mid);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int r = 0; r < N; r++) begin
         wq[r].delete();
         exp_q[r].delete();
      end
      exp_ptr = 0;
      if (mid) begin
         @(negedge clk);
         chk("rst_mid_acc_reset", acc_reset, 1);
      end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   // Requester drivers: present the queue head, advance on acceptance or after
   // one cycle of a bubble. Idle lanes carry random data and random last.
   initial begin
      for (int r = 0; r < N; r++) begin
         v[r] = 1'b0; d[r] = '0; l[r] = 1'b0; shown_bub[r] = 1'b0; beats[r] = 0;
      end
      forever begin
         @(posedge clk); #2;
         for (int r = 0; r < N; r++) begin
            if (wq[r].size() > 0) begin
               if (wq[r][0].bub) begin
                  if (shown_bub[r]) wq[r].delete(0);
               end else if (took[r]) begin
                  wq[r].delete(0);
                  beats[r]++;
               end
            end
            shown_bub[r] = 1'b0;
            if (wq[r].size() == 0) begin
               v[r] = 1'b0; l[r] = 1'($urandom_range(0, 1)); d[r] = 16'($urandom);
            end else if (wq[r][0].bub) begin
               v[r] = 1'b0; l[r] = 1'b1; d[r] = 16'($urandom); shown_bub[r] = 1'b1;
            end else begin
               v[r] = 1'b1; l[r] = wq[r][0].last; d[r] = wq[r][0].data;
            end
         end
      end
   end

   // Monitor: protocol invariants every cycle, scoreboard on each accepted result.
   initial begin
      logic         pv_hold, pv_last, pv_acc, found;
      logic [W-1:0] h_data;
      logic [1:0]   h_id;
      logic [C-1:0] h_cnt;
      logic         h_ovf;
      logic [N-1:0] h_grant;
      int           e_id;
      exp_t         e;
      pv_hold = 1'b0; pv_last = 1'b0; pv_acc = 1'b0;
      for (int r = 0; r < N; r++) took[r] = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            pv_hold = 1'b0; pv_last = 1'b0; pv_acc = 1'b0;
            for (int r = 0; r < N; r++) took[r] = 1'b0;
         end else begin
            for (int r = 0; r < N; r++) took[r] = req_valid[r] & req_ready[r];
            chk("grant_onehot", ($countones(grant) <= 1), 1);
            chk("acc_reset_iff_idle", acc_reset, (grant == '0));
            chk("ready_owner_only", (req_ready & ~grant), 0);
            if (res_valid) chk("ready_low_in_result", req_ready, 0);
            if (pv_last) chk("res_latency", res_valid, 1);
            if (pv_acc) begin
               chk("gap_grant", grant, 0);
               chk("gap_acc_reset", acc_reset, 1);
               chk("gap_res_valid", res_valid, 0);
            end
            if (pv_hold) begin
               chk("hold_valid", res_valid, 1);
               chk("hold_data", res_data, h_data);
               chk("hold_id", res_id, h_id);
               chk("hold_count", res_count, h_cnt);
               chk("hold_ovf", res_ovf, h_ovf);
               chk("hold_grant", grant, h_grant);
            end
            if (res_valid && res_ready) begin
               found = 1'b0;
               e_id  = 0;
               for (int k = 0; k < N; k++) begin
                  if (!found && exp_q[(exp_ptr + k) % N].size() > 0) begin
                     found = 1'b1;
                     e_id  = (exp_ptr + k) % N;
                  end
               end
               if (!found) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_result: got id %0d data %0d, expected no result", res_id, res_data);
               end else begin
                  e = exp_q[e_id].pop_front();
                  chk("res_id", res_id, e_id);
                  chk("res_data", res_data, e.sum);
                  chk("res_count", res_count, e.cnt);
                  chk("res_ovf", res_ovf, e.ovf);
                  exp_ptr = (e_id + 1) % N;
               end
            end
            pv_last = |(req_valid & req_ready & req_last);
            pv_hold = res_valid & ~res_ready;
            pv_acc  = res_valid & res_ready;
            h_data  = res_data; h_id = res_id; h_cnt = res_count; h_ovf = res_ovf; h_grant = grant;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: no finish by %0t, expected finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int b0;
      n_cmp = 0; n_err = 0; exp_ptr = 0;
      reset = 1'b0; res_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_res_ovf", res_ovf, 0);
      chk("rst_acc_reset", acc_reset, 1);
      chk("rst_acc_in", acc_in, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Requester 0: 5,5,7 -> 17
      bw.delete(); bw.push_back(16'd5); bw.push_back(16'd5); bw.push_back(16'd7);
      issue(0, 0, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = (grant != '0);
      end
      chk("t1_grant", grant, 4'b0001);
      drain(200, 1'b0);

      // All four with one word each, from pointer 0
      do_reset(1'b0);
      for (int r = 0; r < N; r++) begin
         bw.delete(); bw.push_back(16'(r + 1));
         issue(r, 0, 1'b0);
      end
      drain(200, 1'b0);

      // Carry out of 16 bits
      bw.delete(); bw.push_back(16'hFFF0); bw.push_back(16'h0020);
      issue(2, 0, 1'b0);
      drain(200, 1'b0);

      // Bubbles mid-burst, result held with res_ready low, competitor waiting
      res_ready = 1'b0;
      bw.delete(); bw.push_back(16'd10); bw.push_back(16'd10);
      issue(1, 3, 1'b0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = res_valid;
      end
      chk("t4_res_valid_seen", res_valid, 1);
      @(posedge clk); #1;
      bw.delete(); bw.push_back(16'd9);
      issue(2, 0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t4_hold_valid", res_valid, 1);
      chk("t4_hold_data", res_data, 20);
      chk("t4_hold_grant", grant, 4'b0010);
      @(posedge clk); #1;
      res_ready = 1'b1;
      drain(200, 1'b0);

      // Beat counter saturation: 300 ones
      bw.delete();
      for (int i = 0; i < 300; i++) bw.push_back(16'd1);
      issue(0, 0, 1'b0);
      drain(1000, 1'b0);

      // Reset after two beats abandons the burst and the pointer returns to 0
      bw.delete();
      for (int i = 1; i <= 5; i++) bw.push_back(16'(i));
      issue(1, 0, 1'b0);
      b0 = beats[1];
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = (beats[1] >= b0 + 2);
      end
      chk("t6_two_beats", seen, 1);
      do_reset(1'b1);
      @(negedge clk);
      chk("t6_grant", grant, 0);
      chk("t6_res_valid", res_valid, 0);
      chk("t6_acc_reset", acc_reset, 1);
      chk("t6_acc_out", acc_out, 0);
      chk("t6_req_ready", req_ready, 0);
      @(posedge clk); #1;
      bw.delete(); bw.push_back(16'd3);
      issue(3, 0, 1'b0);
      bw.delete(); bw.push_back(16'd5);
      issue(1, 0, 1'b0);
      drain(200, 1'b0);

      // Random bursts on every requester, random bubbles and res_ready
      for (int r = 0; r < N; r++) begin
         for (int b = 0; b < 3; b++) begin
            bw.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
               if ($urandom_range(0, 1) == 1) bw.push_back(16'($urandom));
               else                           bw.push_back(16'($urandom_range(0, 255)));
            end
            issue(r, 0, 1'b1);
         end
      end
      drain(5000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
